sprite_anim_sequencer: RTL

- Multi-channel sprite animation frame sequencer, clocked in the pixel domain.
- Driven once per video frame by the new-frame pulse from video_sig_gen.
- Each channel independently steps a sprite frame index in loop, ping-pong, one-shot or freeze mode, with a programmable hold time per frame.
- frame_out feeds the sprite_frame_number inputs of the graphics instances; replaces ad-hoc wag counters in top_level.

---
 rtl/sprite_anim_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/sprite_anim_sequencer.sv
// Multi-channel sprite frame sequencer stepped by the per-video-frame tick.
// Ports: clk_pixel/sys_rst_n, tick_in, per-channel start/stop/mode/hold/last in, frame/active/done out.
module sprite_anim_sequencer #(
  parameter  int NUM_CHANNELS = 4,
  parameter  int NUM_FRAMES   = 5,
  parameter  int HOLD_W       = 4,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                         clk_pixel,
  input  logic                         sys_rst_n,
  input  logic                         tick_in,
  input  logic [NUM_CHANNELS-1:0]      start_in,
  input  logic [NUM_CHANNELS-1:0]      stop_in,
  input  logic [2*NUM_CHANNELS-1:0]    mode_in,
  input  logic [HOLD_W*NUM_CHANNELS-1:0] hold_in,
  input  logic [FW*NUM_CHANNELS-1:0]   last_in,
  output logic [FW*NUM_CHANNELS-1:0]   frame_out,
  output logic [NUM_CHANNELS-1:0]      active_out,
  output logic [NUM_CHANNELS-1:0]      done_out
);

  typedef enum logic [1:0] {
    LOOP   = 2'b00,
    PING   = 2'b01,
    ONCE   = 2'b10,
    FREEZE = 2'b11
  } mode_t;

  localparam logic [FW-1:0]     MAXF = FW'(NUM_FRAMES - 1);
  localparam logic [FW-1:0]     F1   = FW'(1);
  localparam logic [HOLD_W-1:0] H1   = HOLD_W'(1);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    mode_t             mode_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] cnt_q;
    logic [FW-1:0]     last_q;
    logic [FW-1:0]     frame_q;
    logic              back_q;
    logic              active_q;
    logic              done_q;
    logic [FW-1:0]     last_c;

    // Sheets shorter than the field width can hold get clamped
    assign last_c = (last_in[c*FW +: FW] > MAXF) ? MAXF
                                                 : last_in[c*FW +: FW];

    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        mode_q   <= LOOP;
        hold_q   <= '0;
        last_q   <= '0;
        cnt_q    <= '0;
        frame_q  <= '0;
        back_q   <= 1'b0;
        active_q <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (start_in[c]) begin
          // Start overrides stop and swallows a same-cycle tick
          mode_q   <= mode_t'(mode_in[2*c +: 2]);
          hold_q   <= hold_in[c*HOLD_W +: HOLD_W];
          last_q   <= last_c;
          cnt_q    <= '0;
          frame_q  <= '0;
          back_q   <= 1'b0;
          active_q <= 1'b1;
        end else if (stop_in[c]) begin
          active_q <= 1'b0;
        end else if (tick_in && active_q && mode_q != FREEZE) begin
          if (cnt_q != hold_q) begin
            cnt_q <= cnt_q + H1;
          end else begin
            cnt_q <= '0;
            unique case (mode_q)
              LOOP: begin
                frame_q <= (frame_q == last_q) ? '0 : frame_q + F1;
              end
              PING: begin
                if (!back_q) begin
                  if (frame_q >= last_q) begin
                    back_q  <= 1'b1;
                    frame_q <= (last_q == '0) ? '0 : last_q - F1;
                  end else begin
                    frame_q <= frame_q + F1;
                  end
                end else if (frame_q == '0) begin
                  back_q  <= 1'b0;
                  frame_q <= (last_q == '0) ? '0 : F1;
                end else begin
                  frame_q <= frame_q - F1;
                end
              end
              ONCE: begin
                if (frame_q == last_q) begin
                  active_q <= 1'b0;
                  done_q   <= 1'b1;
                end else begin
                  frame_q <= frame_q + F1;
                end
              end
              FREEZE: begin
              end
            endcase
          end
        end
      end
    end

    assign frame_out[c*FW +: FW] = frame_q;
    assign active_out[c]         = active_q;
    assign done_out[c]           = done_q;
  end

endmodule
